cobs_rx_fifo: RTL
=================

Name: cobs_rx_fifo

Overview:
Receive-side counterpart of the transmit FIFO. It consumes the raw byte stream from the UART receiver and COBS-decodes it frame by frame. Decoded bytes are buffered and become visible to the core only once their frame is complete and error-free. The core drains the buffer through two CSRs: a byte-pop CSR and a status CSR.

Parameters:
RxQueueSize, 64, decoded-entry capacity; power of two; usable capacity is RxQueueSize-1.
ByteAddr, FifoRxByteCsrAddr, CSR address of the byte-pop register.
StatAddr, FifoRxStatusCsrAddr, CSR address of the status register.

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous reset, active-high
rx_data  in  8  byte from UART receiver
rx_valid  in  1  one-cycle strobe; rx_data valid
csr_enable  in  1  CSR access this cycle
csr_addr  in  CsrAddrT  CSR address
csr_op  in  csr_op_t  CSR operation
rs1_zimm  in  r  immediate/rs1 field
rs1_data  in  word  rs1 value
csr_data_out  out  word  CSR read data
have_data  out  1  committed, unread entries exist
rx_error  out  1  sticky decode/overflow error

Behaviour:
- Reset (one cycle): rd_ptr = wr_ptr = wr_tmp = 0, decoder in IDLE, pending_zero = 0, sticky error = 0. Outputs after reset: have_data = 0, rx_error = 0, csr_data_out = 0.
- Queue entry is 9 bits: {eof, data[7:0]}.
- Pointers: wr_ptr is the committed write pointer; wr_tmp is the speculative write pointer; rd_ptr is the read pointer.
- Pointer arithmetic wraps modulo RxQueueSize.
- Decoder state machine, evaluated only on cycles with rx_valid = 1. It performs at most one queue write per accepted byte.
  - IDLE, expecting a code byte:
    - rx_data = 0 is a delimiter. If wr_tmp != wr_ptr, commit the frame: set eof of entry wr_tmp-1, then wr_ptr <= wr_tmp. An empty frame commits nothing. Clear pending_zero.
    - rx_data = c != 0: if pending_zero, write 0x00 at wr_tmp. Then set cnt = c-1 and flag255 = (c == 255).
    - Next state is DATA if cnt > 0. Otherwise stay in IDLE with pending_zero = 1.
  - DATA:
    - rx_data != 0: write it at wr_tmp and decrement cnt.
    - When cnt reaches 0, return to IDLE with pending_zero = !flag255.
    - rx_data = 0 (premature delimiter): error. Set sticky error, wr_tmp <= wr_ptr, go to IDLE. This zero resynchronises the decoder.
  - DISCARD:
    - Ignore every byte until 0x00.
    - On 0x00, go to IDLE, set wr_tmp <= wr_ptr, clear pending_zero.
- Overflow: any write attempted while (wr_tmp+1) == rd_ptr is an error.
  - Set sticky error, wr_tmp <= wr_ptr, enter DISCARD.
  - No committed data is lost.
- Pop:
  - Trigger: csr_enable and csr_addr == ByteAddr, for any csr_op.
  - If rd_ptr != wr_ptr, rd_ptr increments on that edge. An access while empty is a no-op.
- CSR read data (combinational, same cycle):
  - At ByteAddr: {22'b0, eof, valid, data}. valid = (rd_ptr != wr_ptr); data and eof come from queue[rd_ptr]. When not valid, bits 9:0 are zero.
  - At StatAddr: {count[15:0] at bits 31:16, 14'b0, error, have_data}.
  - At any other address, or when csr_enable = 0: 0.
  - Writes to either address are ignored.
  - Any access to StatAddr clears the sticky error on that edge. A new error in the same cycle wins.
- have_data is registered: 1 when wr_ptr != rd_ptr after the edge. Latency is one cycle after commit.
- Simultaneous events:
  - Pop and decoder write/commit in one cycle are independent; both take effect.
  - A pop never passes wr_ptr.
- Reset mid-frame: all speculative and committed data are dropped.

Decomposition:
- Shared package (config_pkg) holds:
  - constants FifoRxByteCsrAddr, FifoRxStatusCsrAddr, RxQueueSize;
  - typedefs RxPtrT (logic [$clog2(RxQueueSize)-1:0]), RxEntryT (9-bit struct), CobsRxStateT (enum IDLE/DATA/DISCARD).
- One sub-module, cobs_rx_decoder. It contains the state machine, cnt, flag255 and pending_zero. Its outputs are wr_en, wr_byte, commit, abort and err.
- cobs_rx_fifo owns the queue, pointers and CSR logic.

Test Plan:
1. Send 03 11 22 02 33 00. Expect have_data = 1 one cycle after the final 00. Popping yields {valid,data} = 11, 22, 00, 33, with eof = 1 only on 33. The fifth read shows valid = 0.
2. Send 01 01 00. Expect one decoded byte, 00, with eof = 1. Then send 00 00 alone: no entries and no error.
3. Send FF followed by 254 bytes of 0x01, then 01 00. Expect 254 decoded 0x01 bytes; no zero is inserted after the FF group, and the last entry has eof = 1.
4. Send 05 AA 00 (premature delimiter), then 02 BB 00. Expect rx_error = 1; the queue holds only BB with eof = 1. A StatAddr read clears the error.
5. With RxQueueSize = 8, commit a 4-byte frame, then send a 6-byte frame. Expect overflow: rx_error = 1, the 4 committed bytes remain intact, and the second frame is discarded through its 00.
6. Pop continuously while a frame streams in, and assert reset_i mid-frame. After reset: have_data = 0 and count = 0, and the next clean frame decodes correctly.

Source files
------------

// File: rtl/config_pkg.sv
// Purpose : shared constants and types for the COBS receive FIFO and its decoder.
// Latency : n/a (package).
// Backpressure: n/a (package).
package config_pkg;

    localparam int RxQueueSize = 64;

    typedef logic [11:0] CsrAddrT;
    typedef logic [31:0] WordT;
    typedef logic [4:0]  RegT;

    localparam CsrAddrT FifoRxByteCsrAddr   = 12'h8C2;
    localparam CsrAddrT FifoRxStatusCsrAddr = 12'h8C3;

    typedef enum logic [1:0] {
        CSR_NONE = 2'd0,
        CSR_RW   = 2'd1,
        CSR_RS   = 2'd2,
        CSR_RC   = 2'd3
    } csr_op_t;

    typedef logic [$clog2(RxQueueSize)-1:0] RxPtrT;

    // One decoded queue entry: eof marks the last byte of a committed frame.
    typedef struct packed {
        logic       eof;
        logic [7:0] data;
    } RxEntryT;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DATA    = 2'd1,
        DISCARD = 2'd2
    } CobsRxStateT;

endpackage

// File: rtl/cobs_rx_decoder.sv
// Purpose : COBS frame decoder; turns raw UART bytes into queue write/commit/abort strobes.
// Latency : strobes are combinational from the accepted byte; state advances on the same edge.
// Backpressure: none upstream; full_i turns a write into an overflow abort and DISCARD.
// Ports   : clk_i/reset_i, rx_data_i/rx_valid_i (byte in), full_i (queue has no room),
//           wr_en_o/wr_byte_o (speculative write), commit_o (delimiter seen),
//           abort_o (rewind speculative pointer), err_o (decode or overflow error).
module cobs_rx_decoder
    import config_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    input  logic       full_i,
    output logic       wr_en_o,
    output logic [7:0] wr_byte_o,
    output logic       commit_o,
    output logic       abort_o,
    output logic       err_o
);

    CobsRxStateT state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        flag255_q, flag255_d;
    logic        pend_zero_q, pend_zero_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            flag255_q   <= 1'b0;
            pend_zero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            flag255_q   <= flag255_d;
            pend_zero_q <= pend_zero_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        flag255_d   = flag255_q;
        pend_zero_d = pend_zero_q;
        wr_en_o     = 1'b0;
        wr_byte_o   = rx_data_i;
        commit_o    = 1'b0;
        abort_o     = 1'b0;
        err_o       = 1'b0;

        if (rx_valid_i) begin
            case (state_q)
                IDLE: begin
                    if (rx_data_i == 8'h00) begin
                        // Delimiter; the FIFO ignores a commit of an empty frame.
                        commit_o    = 1'b1;
                        pend_zero_d = 1'b0;
                    end else if (pend_zero_q && full_i) begin
                        err_o       = 1'b1;
                        abort_o     = 1'b1;
                        pend_zero_d = 1'b0;
                        state_d     = DISCARD;
                    end else begin
                        // The zero implied by the previous group is only emitted
                        // once we know the frame continues past it.
                        wr_en_o     = pend_zero_q;
                        wr_byte_o   = 8'h00;
                        cnt_d       = rx_data_i - 8'd1;
                        flag255_d   = (rx_data_i == 8'hFF);
                        if (rx_data_i != 8'h01) begin
                            pend_zero_d = 1'b0;
                            state_d     = DATA;
                        end else begin
                            pend_zero_d = 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (rx_data_i == 8'h00) begin
                        // Premature delimiter: drop the frame, the zero resyncs us.
                        err_o       = 1'b1;
                        abort_o     = 1'b1;
                        pend_zero_d = 1'b0;
                        state_d     = IDLE;
                    end else if (full_i) begin
                        err_o       = 1'b1;
                        abort_o     = 1'b1;
                        state_d     = DISCARD;
                    end else begin
                        wr_en_o = 1'b1;
                        cnt_d   = cnt_q - 8'd1;
                        if (cnt_q == 8'd1) begin
                            pend_zero_d = !flag255_q;
                            state_d     = IDLE;
                        end
                    end
                end
                DISCARD: begin
                    if (rx_data_i == 8'h00) begin
                        abort_o     = 1'b1;
                        pend_zero_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/cobs_rx_fifo.sv
// Purpose : COBS receive FIFO; decoded bytes are visible to the core only after a clean frame commit.
// Latency : have_data rises one edge after the committing delimiter; CSR read data is combinational.
// Backpressure: none toward the UART; a full queue aborts the frame in flight and flags rx_error.
// Ports   : clk_i/reset_i, rx_data/rx_valid (UART bytes), csr_enable/csr_addr/csr_op/rs1_zimm/rs1_data
//           (CSR access; ByteAddr pops, StatAddr reads count/error and clears error),
//           csr_data_out (read data), have_data (committed entries pending), rx_error (sticky error).
module cobs_rx_fifo #(
    parameter int                RxQueueSize = config_pkg::RxQueueSize,
    parameter config_pkg::CsrAddrT ByteAddr  = config_pkg::FifoRxByteCsrAddr,
    parameter config_pkg::CsrAddrT StatAddr  = config_pkg::FifoRxStatusCsrAddr
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    input  logic                 csr_enable,
    input  config_pkg::CsrAddrT  csr_addr,
    input  config_pkg::csr_op_t  csr_op,
    input  config_pkg::RegT      rs1_zimm,
    input  config_pkg::WordT     rs1_data,
    output config_pkg::WordT     csr_data_out,
    output logic                 have_data,
    output logic                 rx_error
);
    import config_pkg::*;

    localparam int PtrW = $clog2(RxQueueSize);
    typedef logic [PtrW-1:0] ptr_t;

    RxEntryT queue_q [RxQueueSize];

    ptr_t rd_ptr_q, rd_ptr_d;
    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t wr_tmp_q, wr_tmp_d;
    logic err_q, err_d;
    logic have_data_q;

    logic       dec_wr_en, dec_commit, dec_abort, dec_err;
    logic [7:0] dec_wr_byte;

    ptr_t       wr_tmp_inc, wr_tmp_dec, count_w;
    logic       full, rd_valid, frame_nonempty, byte_acc, stat_acc;
    logic [15:0] count16;
    RxEntryT    head;

    // Reads never change state beyond pop/clear, so the write operands are don't-care.
    logic unused_csr_fields;
    assign unused_csr_fields = ^{csr_op, rs1_zimm, rs1_data};

    assign wr_tmp_inc     = wr_tmp_q + ptr_t'(1);
    assign wr_tmp_dec     = wr_tmp_q - ptr_t'(1);
    assign full           = (wr_tmp_inc == rd_ptr_q);
    assign rd_valid       = (rd_ptr_q != wr_ptr_q);
    assign frame_nonempty = (wr_tmp_q != wr_ptr_q);
    assign count_w        = wr_ptr_q - rd_ptr_q;
    assign count16        = 16'(count_w);
    assign byte_acc       = csr_enable && (csr_addr == ByteAddr);
    assign stat_acc       = csr_enable && (csr_addr == StatAddr);
    assign head           = queue_q[rd_ptr_q];

    cobs_rx_decoder u_dec (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .full_i     (full),
        .wr_en_o    (dec_wr_en),
        .wr_byte_o  (dec_wr_byte),
        .commit_o   (dec_commit),
        .abort_o    (dec_abort),
        .err_o      (dec_err)
    );

    always_comb begin
        wr_tmp_d = wr_tmp_q;
        if (dec_abort) begin
            wr_tmp_d = wr_ptr_q;
        end else if (dec_wr_en) begin
            wr_tmp_d = wr_tmp_inc;
        end

        wr_ptr_d = wr_ptr_q;
        if (dec_commit && frame_nonempty) begin
            wr_ptr_d = wr_tmp_q;
        end

        // Compared against the old wr_ptr, so a pop can never overtake a same-cycle commit.
        rd_ptr_d = rd_ptr_q;
        if (byte_acc && rd_valid) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end

        // A fresh error outranks the clear-on-status-read.
        err_d = err_q;
        if (dec_err) begin
            err_d = 1'b1;
        end else if (stat_acc) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            wr_tmp_q    <= '0;
            err_q       <= 1'b0;
            have_data_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_tmp_q    <= wr_tmp_d;
            err_q       <= err_d;
            have_data_q <= (wr_ptr_d != rd_ptr_d);
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk_i) begin
        if (dec_wr_en) begin
            queue_q[wr_tmp_q] <= {1'b0, dec_wr_byte};
        end
        if (dec_commit && frame_nonempty) begin
            queue_q[wr_tmp_dec].eof <= 1'b1;
        end
    end

    always_comb begin
        csr_data_out = '0;
        if (byte_acc && rd_valid) begin
            csr_data_out = {22'b0, head.eof, 1'b1, head.data};
        end else if (stat_acc) begin
            csr_data_out = {count16, 14'b0, err_q, have_data_q};
        end
    end

    assign have_data = have_data_q;
    assign rx_error  = err_q;

endmodule
